// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  // Smallest r with 2**r >= value; used at elaboration time to size counters.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// Operand/result bundle between the start logic and the multiplier.
interface seq_multiplier_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic               signed_mode;
  logic               start;
  logic [2*WIDTH-1:0] product;
  logic               busy;
  logic               done;

  // Requester side: supplies operands and start, observes the result.
  modport master (
    output multiplicand, multiplier, signed_mode, start,
    input  product, busy, done
  );

  // Multiplier side.
  modport slave (
    input  multiplicand, multiplier, signed_mode, start,
    output product, busy, done
  );
endinterface

// File: rtl/twos_abs.sv
// Magnitude of an operand that is either unsigned or two's complement.
// The most negative value negates to itself; its bit pattern is then read
// as the unsigned magnitude 2**(WIDTH-1), which is the correct result.
module twos_abs #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic             signed_i,
  output logic [WIDTH-1:0] mag_o,
  output logic             neg_o
);

  assign neg_o = signed_i & value_i[WIDTH-1];
  assign mag_o = neg_o ? -value_i : value_i;

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: multiplies magnitudes over WIDTH cycles,
// then applies the result sign in one extra cycle. Fixed latency of
// WIDTH+1 edges from the accepting edge; the product holds between ops.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  seq_multiplier_if.slave bus
);

  localparam int CNT_W = clog2(WIDTH + 1);

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               neg_a;
  logic               neg_b;

  state_e             state_q;
  logic               sign_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] product_q;
  logic               busy_q;
  logic               done_q;

  twos_abs #(.WIDTH(WIDTH)) u_abs_a (
    .value_i  (bus.multiplicand),
    .signed_i (bus.signed_mode),
    .mag_o    (mag_a),
    .neg_o    (neg_a)
  );

  twos_abs #(.WIDTH(WIDTH)) u_abs_b (
    .value_i  (bus.multiplier),
    .signed_i (bus.signed_mode),
    .mag_o    (mag_b),
    .neg_o    (neg_b)
  );

  // Control FSM and datapath: accept in IDLE, add/shift in CALC, sign-fix in FIX.
  // NOTE: every register here uses <= so all state updates see the
  // pre-edge values; mixing in = would make results depend on statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      sign_q    <= 1'b0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            sign_q   <= neg_a ^ neg_b;
            mcand_q  <= {{WIDTH{1'b0}}, mag_a};
            mplier_q <= mag_b;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= CALC;
          end
        end
        CALC: begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= FIX;
        end
        FIX: begin
          // Negating zero yields zero, so there is no negative-zero result.
          product_q <= sign_q ? -acc_q : acc_q;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.product = product_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier at WIDTH=8 and WIDTH=16.
module tb_seq_multiplier;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  seq_multiplier_if #(.WIDTH(8))  if8  ();
  seq_multiplier_if #(.WIDTH(16)) if16 ();

  seq_multiplier #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(if8.slave));
  seq_multiplier #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_done(input bit wide);
    return wide ? if16.done : if8.done;
  endfunction

  function automatic logic get_busy(input bit wide);
    return wide ? if16.busy : if8.busy;
  endfunction

  function automatic logic [31:0] get_prod(input bit wide);
    return wide ? if16.product : {16'h0, if8.product};
  endfunction

  task automatic drive(input bit wide, input logic [15:0] a, input logic [15:0] b,
                       input logic sm, input logic st);
    if (wide) begin
      if16.multiplicand = a;
      if16.multiplier   = b;
      if16.signed_mode  = sm;
      if16.start        = st;
    end else begin
      if8.multiplicand = a[7:0];
      if8.multiplier   = b[7:0];
      if8.signed_mode  = sm;
      if8.start        = st;
    end
  endtask

  // One complete operation with a single-cycle start; checks latency,
  // busy length, product hold during the op, result and done width.
  task automatic op(input bit wide, input logic [15:0] a, input logic [15:0] b,
                    input logic sm, input logic [31:0] exp, input string tag);
    int e;
    int busy_cnt;
    int lat;
    logic [31:0] prev;
    lat  = wide ? 17 : 9;
    prev = get_prod(wide);
    drive(wide, a, b, sm, 1'b1);
    step();
    // Operands may change freely once accepted.
    drive(wide, 16'hA5C3, 16'h3C5A, ~sm, 1'b0);
    e = 0;
    busy_cnt = 0;
    while (!get_done(wide) && e < 40) begin
      if (get_busy(wide)) busy_cnt++;
      if (e == 4) check({tag, "_hold"}, get_prod(wide), prev);
      step();
      e++;
    end
    check({tag, "_latency"}, e, lat);
    check({tag, "_busy_cycles"}, busy_cnt, lat);
    check({tag, "_product"}, get_prod(wide), exp);
    check({tag, "_busy_at_done"}, get_busy(wide), 1'b0);
    step();
    check({tag, "_done_pulse"}, get_done(wide), 1'b0);
    check({tag, "_product_kept"}, get_prod(wide), exp);
  endtask

  initial begin : stim
    int e;
    int dcnt;
    int t_done[$];

    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    drive(1'b1, 16'h0, 16'h0, 1'b0, 1'b0);

    // Reset values
    #1 rst = 1'b0;
    #2;
    check("rst_product8", if8.product, 16'h0);
    check("rst_busy8", if8.busy, 1'b0);
    check("rst_done8", if8.done, 1'b0);
    check("rst_product16", if16.product, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Unsigned and signed 8-bit vectors
    op(1'b0, 16'hFF, 16'hFF, 1'b0, 32'hFE01, "u_ff_ff");
    op(1'b0, 16'hFD, 16'h05, 1'b1, 32'hFFF1, "s_m3_5");
    op(1'b0, 16'hFD, 16'h05, 1'b0, 32'h04F1, "u_fd_5");
    op(1'b0, 16'h80, 16'h80, 1'b1, 32'h4000, "s_min_min");
    op(1'b0, 16'h80, 16'h01, 1'b1, 32'hFF80, "s_min_1");
    op(1'b0, 16'hFF, 16'h01, 1'b1, 32'hFFFF, "s_m1_1");
    op(1'b0, 16'h00, 16'hFF, 1'b1, 32'h0000, "s_zero");

    // Start re-pulsed during a busy operation is ignored
    drive(1'b0, 16'h03, 16'h05, 1'b0, 1'b1);
    step();
    drive(1'b0, 16'h0B, 16'h0D, 1'b0, 1'b0);
    dcnt = 0;
    for (int i = 1; i <= 22; i++) begin
      if8.start = (i == 3 || i == 5);
      step();
      if (if8.done) begin
        dcnt++;
        check("repulse_product", if8.product, 16'h000F);
        check("repulse_when", i, 9);
      end
    end
    check("repulse_done_count", dcnt, 1);

    // Start held high re-triggers with a period of WIDTH+2
    drive(1'b0, 16'h07, 16'h06, 1'b0, 1'b1);
    e = 0;
    while (t_done.size() < 3 && e < 60) begin
      step();
      e++;
      if (if8.done) begin
        t_done.push_back(e);
        check("held_product", if8.product, 16'h002A);
      end
    end
    if8.start = 1'b0;
    check("held_done_count", t_done.size(), 3);
    if (t_done.size() == 3) begin
      check("held_first", t_done[0], 10);
      check("held_period1", t_done[1] - t_done[0], 10);
      check("held_period2", t_done[2] - t_done[1], 10);
    end
    step();

    // Asynchronous reset in the middle of CALC aborts the operation
    drive(1'b0, 16'h55, 16'h03, 1'b0, 1'b1);
    step();
    if8.start = 1'b0;
    repeat (4) step();
    check("mid_busy_before", if8.busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("async_product", if8.product, 16'h0);
    check("async_busy", if8.busy, 1'b0);
    check("async_done", if8.done, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (if8.done || if8.busy) dcnt++;
    end
    check("post_rst_quiet", dcnt, 0);
    op(1'b0, 16'h0C, 16'h0C, 1'b0, 32'h0090, "u_12_12");

    // 16-bit instance
    op(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "w16_u_max");
    op(1'b1, 16'hFFFF, 16'h0002, 1'b1, 32'hFFFFFFFE, "w16_s_m1_2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
